// File: rtl/ddr3_rd_stream_engine_pkg.sv
// Shared types and derived constants for the DDR3 read stream engine.
// Derived values are functions because they depend on the top's parameters.
package ddr3_rd_stream_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SPACE,
    ST_ISSUE,
    ST_WAIT_DATA
  } rd_state_e;

  // One controller address unit per DQ byte-lane beat: 8 units per wide word.
  localparam int ADDR_UNITS_PER_WORD = 8;

  function automatic int calc_ratio(input int dq_w, input int user_w);
    return (dq_w * 8) / user_w;
  endfunction

  function automatic int calc_addr_step(input int burst_len);
    return burst_len * ADDR_UNITS_PER_WORD;
  endfunction

  function automatic bit params_legal(input int addr_w, input int dq_w, input int user_w,
                                      input int burst_len, input int fifo_depth, input int len_w);
    return (addr_w > 0) && (len_w > 0) && (dq_w > 0) && (user_w > 0) &&
           ((dq_w * 8) % user_w == 0) && (burst_len >= 1) && (burst_len <= 16) &&
           (fifo_depth >= 2 * burst_len) && ((fifo_depth & (fifo_depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/ddr3_rd_stream_engine_fifo.sv
// First-word-fall-through synchronous FIFO for wide read words, with used count.
module sync_fifo_wide #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   used
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign used    = wr_ptr_q - rd_ptr_q;
  assign empty   = (used == '0);
  assign full    = (used == (AW+1)'(DEPTH));
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en && !full)  wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (rd_en && !empty) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ddr3_rd_stream_engine.sv
// Streams a region of DDR3 out as narrow slices: issues one BURST_LEN read at a
// time when the FIFO has room, buffers the beats and gears them down LSB-first.
module ddr3_rd_stream_engine
  import ddr3_rd_stream_engine_pkg::*;
#(
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int MEM_DQ_WIDTH    = 16,
  parameter int USER_DATA_WIDTH = 8,
  parameter int BURST_LEN       = 4,
  parameter int FIFO_DEPTH      = 64,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                         ddr3_core_clk,
  input  logic                         ddr3_core_rst,
  input  logic                         ddrc_init_done,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [CTRL_ADDR_WIDTH-1:0]   req_addr,
  input  logic [LEN_WIDTH-1:0]         req_len,
  input  logic                         req_loop,
  input  logic                         stop,
  output logic                         read_en,
  input  logic                         read_done_p,
  output logic [CTRL_ADDR_WIDTH-1:0]   ddr3_rd_addr,
  output logic [3:0]                   ddr3_axi_id,
  output logic [3:0]                   ddr3_axi_len,
  output logic                         ddr3_axi_ap,
  input  logic                         ddr3_rd_valid,
  input  logic [MEM_DQ_WIDTH*8-1:0]    ddr3_rd_data,
  output logic [USER_DATA_WIDTH-1:0]   user_rd_data,
  output logic                         user_rd_valid,
  input  logic                         user_rd_ready,
  output logic                         user_rd_last,
  output logic                         busy,
  output logic                         err_overflow
);
  localparam int W     = MEM_DQ_WIDTH * 8;
  localparam int RATIO = calc_ratio(MEM_DQ_WIDTH, USER_DATA_WIDTH);
  localparam int STEP  = calc_addr_step(BURST_LEN);
  localparam int FAW   = $clog2(FIFO_DEPTH);
  localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  if (!params_legal(CTRL_ADDR_WIDTH, MEM_DQ_WIDTH, USER_DATA_WIDTH, BURST_LEN,
                    FIFO_DEPTH, LEN_WIDTH)) begin : g_bad_params
    $error("ddr3_rd_stream_engine: illegal parameter combination");
  end

  rd_state_e                  state_q;
  logic                       init_done_q, loop_q, stop_q, read_en_q, err_q;
  logic [CTRL_ADDR_WIDTH-1:0] base_q, addr_q;
  logic [LEN_WIDTH-1:0]       len_q, bidx_q;
  logic [4:0]                 beat_q;

  logic                       fifo_wr, fifo_rd, fifo_empty, fifo_full;
  logic [FAW:0]               fifo_used;
  logic [W:0]                 fifo_wdata, fifo_rdata;

  logic                       gb_vld_q, gb_last_q;
  logic [W-1:0]               gb_data_q;
  logic [SW-1:0]              slice_q;

  logic beat_in, final_beat, last_burst, stop_eff, slice_end;

  assign beat_in    = (state_q == ST_WAIT_DATA) && ddr3_rd_valid;
  assign final_beat = beat_in && (beat_q == 5'(BURST_LEN - 1));
  assign last_burst = ({1'b0, bidx_q} + (LEN_WIDTH+1)'(1)) == {1'b0, len_q};
  assign stop_eff   = stop_q || stop;
  assign fifo_wr    = beat_in && !fifo_full;
  // A pass cut short by a pending stop never gets its last marker.
  assign fifo_wdata = {final_beat && last_burst && !stop_eff, ddr3_rd_data};

  assign busy         = (state_q != ST_IDLE) || !fifo_empty || gb_vld_q;
  assign req_ready    = init_done_q && !busy;
  assign read_en      = read_en_q;
  assign ddr3_rd_addr = addr_q;
  assign ddr3_axi_id  = 4'd0;
  assign ddr3_axi_len = 4'(BURST_LEN - 1);
  assign ddr3_axi_ap  = 1'b0;
  assign err_overflow = err_q;

  always_ff @(posedge ddr3_core_clk) begin
    if (ddr3_core_rst) begin
      state_q     <= ST_IDLE;
      init_done_q <= 1'b0;
      loop_q      <= 1'b0;
      stop_q      <= 1'b0;
      read_en_q   <= 1'b0;
      err_q       <= 1'b0;
      base_q      <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      bidx_q      <= '0;
      beat_q      <= '0;
    end else begin
      init_done_q <= ddrc_init_done;
      if (ddr3_rd_valid && ((state_q != ST_WAIT_DATA) || fifo_full)) err_q <= 1'b1;
      if (stop && (state_q != ST_IDLE)) stop_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            base_q  <= req_addr;
            addr_q  <= req_addr;
            len_q   <= req_len;
            loop_q  <= req_loop;
            bidx_q  <= '0;
            stop_q  <= 1'b0;
            state_q <= ST_WAIT_SPACE;
          end
        end
        ST_WAIT_SPACE: begin
          if (stop_eff || (len_q == '0)) begin
            stop_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (fifo_used <= (FAW+1)'(FIFO_DEPTH - BURST_LEN)) begin
            read_en_q <= 1'b1;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (read_done_p) begin
            read_en_q <= 1'b0;
            beat_q    <= '0;
            state_q   <= ST_WAIT_DATA;
          end
        end
        ST_WAIT_DATA: begin
          if (beat_in) begin
            beat_q <= beat_q + 5'd1;
            if (final_beat) begin
              if (!last_burst && !stop_eff) begin
                bidx_q  <= bidx_q + LEN_WIDTH'(1);
                addr_q  <= addr_q + CTRL_ADDR_WIDTH'(STEP);
                state_q <= ST_WAIT_SPACE;
              end else if (loop_q && !stop_eff) begin
                bidx_q  <= '0;
                addr_q  <= base_q;
                state_q <= ST_WAIT_SPACE;
              end else begin
                stop_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sync_fifo_wide #(
    .WIDTH (W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (ddr3_core_clk),
    .rst     (ddr3_core_rst),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .used    (fifo_used)
  );

  // Gearbox refills on the same cycle its final slice leaves: one slice per clock.
  assign slice_end     = (slice_q == SW'(RATIO - 1));
  assign fifo_rd       = !fifo_empty && (!gb_vld_q || (user_rd_ready && slice_end));
  assign user_rd_valid = gb_vld_q;
  assign user_rd_data  = gb_data_q[USER_DATA_WIDTH-1:0];
  assign user_rd_last  = gb_vld_q && gb_last_q && slice_end;

  always_ff @(posedge ddr3_core_clk) begin
    if (ddr3_core_rst) begin
      gb_vld_q  <= 1'b0;
      gb_last_q <= 1'b0;
      gb_data_q <= '0;
      slice_q   <= '0;
    end else if (fifo_rd) begin
      gb_vld_q  <= 1'b1;
      gb_last_q <= fifo_rdata[W];
      gb_data_q <= fifo_rdata[W-1:0];
      slice_q   <= '0;
    end else if (gb_vld_q && user_rd_ready) begin
      if (slice_end) begin
        gb_vld_q <= 1'b0;
      end else begin
        slice_q   <= slice_q + SW'(1);
        gb_data_q <= gb_data_q >> USER_DATA_WIDTH;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_rd_stream_engine.sv
// Bench for ddr3_rd_stream_engine: random controller/sink models plus
// directed scenarios, checked against a queue-based reference of the stream.
module tb_ddr3_rd_stream_engine;
  localparam int AW = 28, DQ = 16, UW = 8, BL = 4, FD = 64, LW = 16;
  localparam int W = DQ * 8, RATIO = W / UW, STEP = BL * 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, init_done, req_valid, req_ready, req_loop, stop;
  logic          read_en, read_done_p, rd_valid, user_rd_valid, user_rd_ready;
  logic          user_rd_last, busy, err_overflow, axi_ap;
  logic [AW-1:0] req_addr, rd_addr;
  logic [LW-1:0] req_len;
  logic [3:0]    axi_id, axi_len;
  logic [W-1:0]  rd_data;
  logic [UW-1:0] user_rd_data;

  ddr3_rd_stream_engine #(
    .CTRL_ADDR_WIDTH (AW), .MEM_DQ_WIDTH (DQ), .USER_DATA_WIDTH (UW),
    .BURST_LEN (BL), .FIFO_DEPTH (FD), .LEN_WIDTH (LW)
  ) dut (
    .ddr3_core_clk (clk), .ddr3_core_rst (rst), .ddrc_init_done (init_done),
    .req_valid (req_valid), .req_ready (req_ready), .req_addr (req_addr),
    .req_len (req_len), .req_loop (req_loop), .stop (stop),
    .read_en (read_en), .read_done_p (read_done_p), .ddr3_rd_addr (rd_addr),
    .ddr3_axi_id (axi_id), .ddr3_axi_len (axi_len), .ddr3_axi_ap (axi_ap),
    .ddr3_rd_valid (rd_valid), .ddr3_rd_data (rd_data),
    .user_rd_data (user_rd_data), .user_rd_valid (user_rd_valid),
    .user_rd_ready (user_rd_ready), .user_rd_last (user_rd_last),
    .busy (busy), .err_overflow (err_overflow)
  );

  int            nchecks = 0, nfail = 0;
  logic [W-1:0]  exp_words[$];
  logic [AW-1:0] addr_log[$];
  logic [UW:0]   got[$];
  int            ndone = 0;
  int            resp_beats = BL;
  int            rdy_mode = 1;

  // Controller model: accept read_en after a random delay, then return beats.
  initial begin
    read_done_p = 1'b0;
    rd_valid    = 1'b0;
    rd_data     = '0;
    forever begin
      @(negedge clk);
      if (read_en && !rst) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        addr_log.push_back(rd_addr);
        ndone++;
        read_done_p = 1'b1;
        @(negedge clk);
        read_done_p = 1'b0;
        for (int b = 0; b < resp_beats; b++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          rd_data  = {$urandom, $urandom, $urandom, $urandom};
          rd_valid = 1'b1;
          if (b < BL) exp_words.push_back(rd_data);
          @(negedge clk);
          rd_valid = 1'b0;
        end
      end
    end
  end

  // Sink model: drives ready, records every slice that will transfer.
  initial begin
    user_rd_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       user_rd_ready = 1'b0;
        1:       user_rd_ready = 1'b1;
        default: user_rd_ready = 1'($urandom_range(0, 1));
      endcase
      if (user_rd_valid && user_rd_ready && !rst) got.push_back({user_rd_last, user_rd_data});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nchecks++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_all();
    exp_words.delete();
    addr_log.delete();
    got.delete();
    ndone = 0;
  endtask

  task automatic send_req(input logic [AW-1:0] a, input logic [LW-1:0] n, input logic lp);
    int t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_wait", 64'(t < 50), 64'd1);
    req_addr  = a;
    req_len   = n;
    req_loop  = lp;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int t = 0;
    while (busy && t < bound) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_drain"}, 64'(busy), 64'd0);
    cyc(4);
  endtask

  // Expected address of burst i of a pass starting at base, with wrap.
  task automatic check_addrs(input string tag, input logic [AW-1:0] base, input int n, input bit same);
    chk({tag, "_nbursts"}, 64'(addr_log.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] e;
      e = same ? base : AW'(base + i * STEP);
      chk($sformatf("%s_addr%0d", tag, i),
          (i < addr_log.size()) ? 64'(addr_log[i]) : 64'hDEAD, 64'(e));
    end
  endtask

  // Slices LSB-first; last on final slice of each complete pass up to npl passes.
  task automatic check_stream(input string tag, input int wpp, input int npl);
    chk({tag, "_nslices"}, 64'(got.size()), 64'(exp_words.size() * RATIO));
    for (int k = 0; k < got.size() && k < exp_words.size() * RATIO; k++) begin
      int i, j;
      logic [W-1:0] sh;
      logic el;
      i  = k / RATIO;
      j  = k % RATIO;
      sh = exp_words[i] >> (j * UW);
      el = (j == RATIO - 1) && ((i + 1) % wpp == 0) && ((i + 1) / wpp <= npl);
      chk($sformatf("%s_slice%0d", tag, k), 64'(got[k]), 64'({el, sh[UW-1:0]}));
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    int n, seen, t, used, stall_bursts;
    rst = 1'b1; init_done = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0;
    req_loop = 1'b0; stop = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("rst_read_en", 64'(read_en), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_user_valid", 64'(user_rd_valid), 64'd0);
    chk("rst_user_last", 64'(user_rd_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err_overflow), 64'd0);
    chk("rst_req_ready_no_init", 64'(req_ready), 64'd0);
    chk("axi_consts", 64'({axi_id, axi_len, axi_ap}), 64'({4'd0, 4'(BL - 1), 1'b0}));
    init_done = 1'b1;
    cyc(2);
    chk("req_ready_init", 64'(req_ready), 64'd1);

    // Two bursts from 0x100 with random backpressure.
    rdy_mode = 2;
    send_req(28'h100, 16'd2, 1'b0);
    wait_drain("basic", 2000);
    check_addrs("basic", 28'h100, 2, 1'b0);
    check_stream("basic", 2 * BL, 1);
    chk("basic_err", 64'(err_overflow), 64'd0);
    clear_all();

    // Zero-length request: accepted, no reads, idle on the following cycle.
    send_req(AW'($urandom), 16'd0, 1'b0);
    cyc(1);
    chk("len0_busy", 64'(busy), 64'd0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (read_en) seen++;
    end
    chk("len0_no_read", 64'(seen + ndone), 64'd0);
    chk("len0_no_data", 64'(got.size()), 64'd0);
    clear_all();

    // Random regions, addresses checked with modulo wrap.
    for (int r = 0; r < 3; r++) begin
      a = AW'($urandom);
      n = $urandom_range(1, 4);
      send_req(a, LW'(n), 1'b0);
      wait_drain($sformatf("rand%0d", r), 3000);
      check_addrs($sformatf("rand%0d", r), a, n, 1'b0);
      check_stream($sformatf("rand%0d", r), n * BL, 1);
      clear_all();
    end

    // Address wrap at the top of the space.
    send_req(28'hFFFFFE0, 16'd2, 1'b0);
    wait_drain("wrap", 2000);
    check_addrs("wrap", 28'hFFFFFE0, 2, 1'b0);
    check_stream("wrap", 2 * BL, 1);
    clear_all();

    // Sink stalled: issue stops once the FIFO can no longer take a whole burst.
    used = 0; stall_bursts = 0;
    while (stall_bursts < 20 && used <= FD - BL) begin
      stall_bursts++;
      used = stall_bursts * BL - 1;  // one word sits in the output gearbox
    end
    rdy_mode = 0;
    send_req(28'h4000, 16'd20, 1'b0);
    cyc(600);
    chk("stall_bursts", 64'(ndone), 64'(stall_bursts));
    chk("stall_read_en", 64'(read_en), 64'd0);
    chk("stall_no_data", 64'(got.size()), 64'd0);
    rdy_mode = 1;
    wait_drain("stall", 4000);
    check_addrs("stall", 28'h4000, 20, 1'b0);
    check_stream("stall", 20 * BL, 1);
    chk("stall_err", 64'(err_overflow), 64'd0);
    clear_all();

    // Loop mode, stop during the third burst: third pass has no last.
    rdy_mode = 2;
    a = AW'($urandom) & ~AW'(STEP - 1);
    send_req(a, 16'd1, 1'b1);
    t = 0;
    while (ndone < 3 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("loop_reach3", 64'(ndone >= 3), 64'd1);
    cyc(1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    wait_drain("loop", 2000);
    check_addrs("loop", a, 3, 1'b1);
    check_stream("loop", BL, 2);
    clear_all();

    // Extra beat after the burst: dropped, sticky error until reset.
    rdy_mode = 1;
    resp_beats = BL + 1;
    send_req(28'h200, 16'd1, 1'b0);
    wait_drain("ovf", 2000);
    chk("ovf_err", 64'(err_overflow), 64'd1);
    check_stream("ovf", BL, 1);
    resp_beats = BL;
    cyc(10);
    chk("ovf_err_sticky", 64'(err_overflow), 64'd1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("ovf_err_cleared", 64'(err_overflow), 64'd0);
    clear_all();

    // Reset in the middle of a burst discards everything.
    resp_beats = 2;
    send_req(28'h300, 16'd1, 1'b0);
    t = 0;
    while (ndone < 1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    cyc(10);
    chk("midrst_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    cyc(1);
    chk("midrst_read_en", 64'(read_en), 64'd0);
    chk("midrst_user_valid", 64'(user_rd_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    resp_beats = BL;
    t = 0;
    while (!req_ready && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    clear_all();

    // Normal operation after the reset.
    rdy_mode = 2;
    a = AW'($urandom);
    send_req(a, 16'd2, 1'b0);
    wait_drain("post", 2000);
    check_addrs("post", a, 2, 1'b0);
    check_stream("post", 2 * BL, 1);
    chk("post_err", 64'(err_overflow), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
